// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 Set-2 key tracker.
// Includes small byte-classification helpers used by the prefix FSM.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] BAT     = 8'hAA;
  localparam logic [7:0] ACK     = 8'hFA;
  localparam logic [7:0] RESEND  = 8'hFE;
  localparam logic [7:0] OVR0    = 8'h00;
  localparam logic [7:0] OVR1    = 8'hFF;

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == OVR0) || (b == OVR1);
  endfunction

  // Keyboard housekeeping bytes that must not disturb a partial prefix.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == BAT) || (b == ACK) || (b == RESEND);
  endfunction

endpackage

// File: rtl/ps2_key_lookup.sv
// Combinational priority match of (scan code, extended flag) to a key index.
// The lowest matching index wins when several table entries collide.
module ps2_key_lookup #(
  parameter int                        NUM_KEYS  = 8,
  parameter logic [NUM_KEYS*8-1:0]     KEY_CODES = {8'h04, 8'h06, 8'h05, 8'h2D,
                                                    8'h23, 8'h1B, 8'h1C, 8'h1D},
  parameter logic [NUM_KEYS-1:0]       KEY_EXT   = {NUM_KEYS{1'b0}}
) (
  input  logic [7:0]                    code_i,
  input  logic                          ext_i,
  output logic                          hit_o,
  output logic [$clog2(NUM_KEYS)-1:0]   idx_o
);
  import ps2_pkg::*;

  localparam int IW = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] match_s;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_match
    assign match_s[g] = (KEY_CODES[8*g +: 8] == code_i) && (KEY_EXT[g] == ext_i);
  end

  // Scan from the top down so the lowest matching index is the last one kept.
  always_comb begin
    idx_o = {IW{1'b0}};
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      idx_o = match_s[i] ? IW'(i) : idx_o;
    end
    hit_o = |match_s;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 key tracker: E0/F0 prefix FSM, per-key held levels, a one-entry
// press/release event register with valid/ready, and a prefix timeout.
module ps2_key_tracker #(
  parameter int                        NUM_KEYS       = 8,
  parameter logic [NUM_KEYS*8-1:0]     KEY_CODES      = {8'h04, 8'h06, 8'h05, 8'h2D,
                                                         8'h23, 8'h1B, 8'h1C, 8'h1D},
  parameter logic [NUM_KEYS-1:0]       KEY_EXT        = {NUM_KEYS{1'b0}},
  parameter int                        PREFIX_TIMEOUT = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_data,
  output logic [NUM_KEYS-1:0]           key_state,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [$clog2(NUM_KEYS)-1:0]   event_key,
  output logic                          event_press,
  output logic                          overflow,
  output logic                          timeout_err
);
  import ps2_pkg::*;

  localparam int             IW      = $clog2(NUM_KEYS);
  localparam int             CW      = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(PREFIX_TIMEOUT - 1);

  ps2_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]   key_state_q, key_state_d;
  logic                  ev_valid_q, ev_valid_d;
  logic [IW-1:0]         ev_key_q, ev_key_d;
  logic                  ev_press_q, ev_press_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;

  logic                  make_s, brk_s, clr_s, ext_s;
  logic                  hit_s;
  logic [IW-1:0]         idx_s;
  logic                  ev_fire_s, ev_press_s, accept_s;

  assign ext_s    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign accept_s = ev_valid_q && event_ready;

  ps2_key_lookup #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_CODES (KEY_CODES),
    .KEY_EXT   (KEY_EXT)
  ) u_lookup (
    .code_i (rx_data),
    .ext_i  (ext_s),
    .hit_o  (hit_s),
    .idx_o  (idx_s)
  );

  // Prefix FSM and timeout counter; a byte arriving on the timeout cycle wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    make_s    = 1'b0;
    brk_s     = 1'b0;
    clr_s     = 1'b0;
    if (rx_done) begin
      cnt_d = {CW{1'b0}};
      if (is_overrun(rx_data)) begin
        clr_s   = 1'b1;
        state_d = ST_IDLE;
      end else if (is_ignored(rx_data)) begin
        state_d = state_q;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == PFX_EXT) begin
              state_d = ST_EXT;
            end else if (rx_data == PFX_BRK) begin
              state_d = ST_BRK;
            end else begin
              make_s = 1'b1;
            end
          end
          ST_EXT: begin
            if (rx_data == PFX_BRK) begin
              state_d = ST_EXT_BRK;
            end else if (rx_data == PFX_EXT) begin
              state_d = ST_EXT;
            end else begin
              make_s  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            brk_s   = 1'b1;
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d   = ST_IDLE;
        cnt_d     = {CW{1'b0}};
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Key levels: typematic makes and breaks of released keys fall through silently.
  always_comb begin
    key_state_d = key_state_q;
    ev_fire_s   = 1'b0;
    ev_press_s  = 1'b0;
    if (clr_s) begin
      key_state_d = {NUM_KEYS{1'b0}};
    end else if (make_s && hit_s && !key_state_q[idx_s]) begin
      key_state_d[idx_s] = 1'b1;
      ev_fire_s          = 1'b1;
      ev_press_s         = 1'b1;
    end else if (brk_s && hit_s && key_state_q[idx_s]) begin
      key_state_d[idx_s] = 1'b0;
      ev_fire_s          = 1'b1;
      ev_press_s         = 1'b0;
    end else begin
      ev_fire_s = 1'b0;
    end
  end

  // One-entry event register; a new event may reuse the slot being accepted.
  always_comb begin
    ev_valid_d = accept_s ? 1'b0 : ev_valid_q;
    ev_key_d   = ev_key_q;
    ev_press_d = ev_press_q;
    overflow_d = overflow_q;
    if (ev_fire_s && (!ev_valid_q || accept_s)) begin
      ev_valid_d = 1'b1;
      ev_key_d   = idx_s;
      ev_press_d = ev_press_s;
    end else if (ev_fire_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State register for all tracker state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      key_state_q <= {NUM_KEYS{1'b0}};
      ev_valid_q  <= 1'b0;
      ev_key_q    <= {IW{1'b0}};
      ev_press_q  <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      ev_valid_q  <= ev_valid_d;
      ev_key_q    <= ev_key_d;
      ev_press_q  <= ev_press_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign key_state   = key_state_q;
  assign event_valid = ev_valid_q;
  assign event_key   = ev_key_q;
  assign event_press = ev_press_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: expected events are queued as bytes are
// driven and popped by a monitor whenever the DUT hands an event over.
module tb_ps2_key_tracker;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] key_state;
  logic       event_valid;
  logic       event_ready = 1'b0;
  logic [2:0] event_key;
  logic       event_press;
  logic       overflow;
  logic       timeout_err;

  int num_cmp = 0;
  int num_err = 0;
  logic [3:0] exp_q[$];

  ps2_key_tracker #(
    .NUM_KEYS       (8),
    .KEY_EXT        (8'h08),
    .PREFIX_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .key_state   (key_state),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_key   (event_key),
    .event_press (event_press),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_cmp++;
    if (got !== exp) begin
      num_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte; returns #1 after the sampling edge, when outputs have updated.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input logic [2:0] k, input logic p);
    exp_q.push_back({k, p});
  endtask

  // Monitor: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (reset_n && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        check_val("ev_unexpected", {event_key, event_press}, 32'hF);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check_val("ev_key", event_key, e[3:1]);
        check_val("ev_press", event_press, e[0]);
      end
    end
  end

  initial begin
    #12;
    check_val("rst_key_state", key_state, 8'h00);
    check_val("rst_valid", event_valid, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    check_val("rst_ev_key", event_key, 3'd0);
    check_val("rst_ev_press", event_press, 1'b0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_timeout", timeout_err, 1'b0);

    // Press and release W
    event_ready = 1'b1;
    push_ev(3'd0, 1'b1);
    send_byte(8'h1D);
    check_val("w_press_ks", key_state, 8'h01);
    check_val("w_press_valid", event_valid, 1'b1);
    push_ev(3'd0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_val("w_rel_ks", key_state, 8'h00);
    idle(2);

    // Typematic repeats produce a single press
    push_ev(3'd0, 1'b1);
    send_byte(8'h1D);
    idle(1);
    send_byte(8'h1D);
    idle(1);
    send_byte(8'h1D);
    check_val("typ_ks", key_state, 8'h01);
    idle(2);
    check_val("typ_no_ev", event_valid, 1'b0);
    push_ev(3'd0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1D);
    idle(2);

    // Extended key 3 (D on E0 23)
    send_byte(8'h23);
    check_val("ext_plain_ks", key_state, 8'h00);
    idle(1);
    check_val("ext_plain_noev", event_valid, 1'b0);
    push_ev(3'd3, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h23);
    check_val("ext_make_ks", key_state, 8'h08);
    push_ev(3'd3, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h23);
    check_val("ext_brk_ks", key_state, 8'h00);
    idle(2);

    // Overflow while consumer stalls
    event_ready = 1'b0;
    push_ev(3'd0, 1'b1);
    send_byte(8'h1D);
    send_byte(8'h1C);
    check_val("ovf_ks", key_state, 8'h03);
    check_val("ovf_flag", overflow, 1'b1);
    check_val("ovf_valid", event_valid, 1'b1);
    check_val("ovf_held_key", event_key, 3'd0);
    check_val("ovf_held_press", event_press, 1'b1);
    event_ready = 1'b1;
    idle(2);
    check_val("ovf_sticky", overflow, 1'b1);

    // Overrun clears held keys silently
    send_byte(8'hFF);
    check_val("ovr_ks", key_state, 8'h00);
    idle(2);
    check_val("ovr_noev", event_valid, 1'b0);

    // Break prefix times out; following byte is a make
    send_byte(8'hF0);
    for (int i = 1; i <= TO + 1; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("to_pulse_%0d", i), timeout_err, (i == TO) ? 1'b1 : 1'b0);
    end
    push_ev(3'd0, 1'b1);
    send_byte(8'h1D);
    check_val("to_then_press_ks", key_state, 8'h01);
    idle(2);

    // Housekeeping byte inside an extended prefix keeps the prefix
    push_ev(3'd3, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hAA);
    send_byte(8'h23);
    check_val("ign_in_ext_ks", key_state, 8'h09);
    idle(2);

    // Reset mid-sequence with an event pending
    event_ready = 1'b0;
    send_byte(8'h1C);
    check_val("pre_rst_valid", event_valid, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_ks", key_state, 8'h00);
    check_val("mid_rst_valid", event_valid, 1'b0);
    check_val("mid_rst_ovf", overflow, 1'b0);
    check_val("mid_rst_key", event_key, 3'd0);
    check_val("mid_rst_press", event_press, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    event_ready = 1'b1;
    idle(1);
    send_byte(8'h23);
    check_val("post_rst_ks", key_state, 8'h00);
    check_val("post_rst_noev", event_valid, 1'b0);
    idle(3);

    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 Set-2 scan-code tracker that sits after the PS/2 receiver, consuming one validated byte per `rx_done` strobe. It decodes the `E0` extended prefix and the `F0` break prefix with a proper prefix state machine and holds a level per mapped key, for any number of keys. It also emits a one-entry press/release event stream with a valid/ready handshake. Auto-repeat suppression, a prefix timeout and overrun recovery make it suitable for driving the motor-control command logic directly.

## Interface
- `NUM_KEYS`, default 8: number of tracked keys; must be ≥2.
- `KEY_CODES`, default {8'h04,8'h06,8'h05,8'h2D,8'h23,8'h1B,8'h1C,8'h1D}: packed `NUM_KEYS*8` bits; key i code at bits [8i+7:8i] (default key0=W, key1=A, key2=S, key3=D, key4=R, key5=F1, key6=F2, key7=F3).
- `KEY_EXT`, default 0: `NUM_KEYS` bits; bit i=1 means key i is matched only when the code is `E0`-prefixed, and 0 means only when it is unprefixed.
- `PREFIX_TIMEOUT`, default 100000: clock cycles allowed between a prefix byte and its completing byte.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_done`  in  1  one-cycle strobe; `rx_data` valid.
- `rx_data`  in  8  received scan byte.
- `key_state`  out  NUM_KEYS  bit i=1 while key i is held.
- `event_valid`  out  1  event pending.
- `event_ready`  in  1  consumer accepts the event.
- `event_key`  out  $clog2(NUM_KEYS)  index of the key for the pending event.
- `event_press`  out  1  1=press, 0=release.
- `overflow`  out  1  sticky; set when an event is dropped; cleared only by reset.
- `timeout_err`  out  1  one-cycle pulse when a prefix times out.

## Operation
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). All transitions happen only on `rx_done` except the timeout.
- IDLE:
  - E0→EXT.
  - F0→BRK.
  - Special codes → stay in IDLE.
  - Other bytes: make, ext=0.
- EXT:
  - F0→EXT_BRK.
  - E0→EXT (redundant prefix).
  - Other bytes: make, ext=1, then IDLE.
- BRK: any byte: break, ext=0, then IDLE.
- EXT_BRK: any byte: break, ext=1, then IDLE.
- Special codes, processed in any state:
  - 00 and FF (overrun): clear all `key_state`, emit no events, go to IDLE.
  - AA (BAT), FA (ack), FE (resend): ignored, state unchanged.
- Lookup: key i matches when `KEY_CODES[i]==byte` and `KEY_EXT[i]==ext`. If several keys match, the lowest index wins. Unmapped codes update no state.
- Make on a key already held: no change and no event (typematic suppression). Make on a released key: set the bit and generate a press event.
- Break on a held key: clear the bit and generate a release event. Break on a released key: ignored.
- Event register:
  - Loads when empty, or when `event_valid&&event_ready` in the same cycle as a new event.
  - If a new event arrives while the register is full and not being accepted, the new event is dropped, `overflow` is set, and `key_state` still updates.
- Timeout: a counter runs in EXT/BRK/EXT_BRK and resets on every `rx_done`. On reaching `PREFIX_TIMEOUT`, the FSM goes to IDLE and `timeout_err` pulses; the prefix is discarded.

## Timing
- Reset values: `key_state`=0, `event_valid`=0, `event_key`=0, `event_press`=0, `overflow`=0, `timeout_err`=0, FSM in IDLE, counter 0.
- Latency: `rx_done` at cycle n → `key_state` and `event_valid` update at cycle n+1 (registered, one cycle).
- `event_valid` stays high with stable `event_key`/`event_press` until the cycle in which `event_ready`=1.
- Timeout fires exactly `PREFIX_TIMEOUT` cycles after the last prefix byte, unless an `rx_done` arrives first. If an `rx_done` and the timeout coincide, the byte wins and is processed in the current state.
- Asserting `reset_n`=0 mid-sequence discards any partial prefix and any pending event immediately.

## Structure
- Package `ps2_pkg`:
  - FSM state typedef.
  - Code constants: PFX_EXT=E0, PFX_BRK=F0, BAT=AA, ACK=FA, RESEND=FE, OVR0=00, OVR1=FF.
- Sub-module `ps2_key_lookup`: combinational priority match of (code, ext) to index plus hit, parametrised by `NUM_KEYS`, `KEY_CODES`, `KEY_EXT`.
- The top level holds the FSM, the key-state register, the event register and the timeout counter.

## Test plan
- Defaults, bytes 1D then F0 1D, `event_ready`=1 → `key_state[0]` goes 1 then 0; events (0, press) then (0, release).
- Bytes 1D 1D 1D (typematic) → exactly one press event; `key_state`=8'h01.
- `KEY_EXT[3]`=1: byte 23 → no change. Bytes E0 23 → `key_state[3]`=1. Bytes E0 F0 23 → `key_state[3]`=0 with a release event.
- `event_ready`=0; bytes 1D then 1C → first event held (key 0), `overflow`=1, `key_state`=8'h03.
- `PREFIX_TIMEOUT`=10: byte F0, wait 10 cycles → `timeout_err` pulse. Then byte 1D → press (not release).
- Hold W and A, then byte FF → `key_state`=0 with no events. Drive `reset_n` low during an E0 F0 sequence → all outputs at reset values.
